// File: rtl/plru_state_array.sv
// Tree pseudo-LRU replacement-state store, one (WAYS-1)-bit heap-ordered
// tree per set. Registered victim lookup with same-set write forwarding,
// touch update on hit/fill, and a one-set-per-cycle sequenced clear.
// Node n (root n=1, children 2n/2n+1) lives in bit n-1 of a set's tree;
// 0 steers the victim to the lower-numbered subtree, 1 to the higher.
module plru_state_array #(
    parameter int NUM_SETS = 256,
    parameter int WAYS     = 2,
    parameter int INDEX_W  = $clog2(NUM_SETS),
    parameter int WAY_W    = $clog2(WAYS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lookup_valid,
    input  logic [INDEX_W-1:0] lookup_index,
    output logic               victim_valid,
    output logic [WAY_W-1:0]   victim_way,
    input  logic               touch_valid,
    input  logic [INDEX_W-1:0] touch_index,
    input  logic [WAY_W-1:0]   touch_way,
    input  logic               clear_start,
    output logic               busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    typedef logic [WAYS-2:0] tree_t;

    state_e               state_q, state_d;
    logic [INDEX_W-1:0]   clear_ptr_q, clear_ptr_d;
    logic                 victim_valid_q, victim_valid_d;
    logic [WAY_W-1:0]     victim_way_q, victim_way_d;
    tree_t                plru_q [NUM_SETS];
    tree_t                plru_d [NUM_SETS];

    // Walk the tree from the root following the stored bits. The tree is
    // widened by one dummy bit at position 0 so node n sits at bit n. The
    // node counter keeps only WAY_W bits; after the last step its low bits
    // are exactly n - WAYS, i.e. the leaf's way number.
    function automatic logic [WAY_W-1:0] walk_victim(input tree_t bits);
        logic [WAYS-1:0]  ext;
        logic [WAY_W-1:0] n;
        ext = {bits, 1'b0};
        n   = WAY_W'(1);
        for (int l = 0; l < WAY_W; l++) begin
            n = (n << 1) | WAY_W'(ext[n]);
        end
        return n;
    endfunction

    // Follow the path to 'way' (MSB first) and point every node on it away
    // from the branch taken.
    function automatic tree_t apply_touch(input tree_t bits, input logic [WAY_W-1:0] way);
        logic [WAYS-1:0]  ext;
        logic [WAY_W-1:0] n;
        logic [WAY_W-1:0] w;
        logic             dir;
        ext = {bits, 1'b0};
        n   = WAY_W'(1);
        w   = way;
        for (int l = 0; l < WAY_W; l++) begin
            dir    = w[WAY_W-1];
            ext[n] = ~dir;
            n      = (n << 1) | WAY_W'(dir);
            w      = w << 1;
        end
        return tree_t'(ext >> 1);
    endfunction

    // Next-state: touch then lookup (so a same-set lookup sees the touch),
    // clear launch from IDLE, and one set zeroed per cycle while clearing.
    always_comb begin
        state_d        = state_q;
        clear_ptr_d    = clear_ptr_q;
        victim_valid_d = 1'b0;
        victim_way_d   = victim_way_q;
        plru_d         = plru_q;
        case (state_q)
            IDLE: begin
                if (touch_valid) begin
                    plru_d[touch_index] = apply_touch(plru_q[touch_index], touch_way);
                end
                if (lookup_valid) begin
                    victim_valid_d = 1'b1;
                    victim_way_d   = walk_victim(plru_d[lookup_index]);
                end
                if (clear_start) begin
                    state_d     = CLEAR;
                    clear_ptr_d = '0;
                end
            end
            CLEAR: begin
                plru_d[clear_ptr_q] = '0;
                if (clear_ptr_q == INDEX_W'(NUM_SETS - 1)) begin
                    state_d     = IDLE;
                    clear_ptr_d = '0;
                end else begin
                    clear_ptr_d = clear_ptr_q + INDEX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset clears every tree and aborts any sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            clear_ptr_q    <= '0;
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                plru_q[s] <= '0;
            end
        end else begin
            state_q        <= state_d;
            clear_ptr_q    <= clear_ptr_d;
            victim_valid_q <= victim_valid_d;
            victim_way_q   <= victim_way_d;
            plru_q         <= plru_d;
        end
    end

    assign victim_valid = victim_valid_q;
    assign victim_way   = victim_way_q;
    assign busy         = (state_q == CLEAR);

endmodule

// File: tb/tb_plru_state_array.sv
// Bench for plru_state_array: three instances (2, 4 and 8 ways, 256 sets)
// share one stimulus stream. The reference model keeps a last-touch
// timestamp per way; at each tree level the victim is in the half that does
// not hold the most recently touched way (lower half if neither was touched).
module tb_plru_state_array;

    localparam int NSETS = 256;
    localparam int NCFG  = 3;
    localparam int WAYS_OF [NCFG] = '{2, 4, 8};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       lookup_valid = 1'b0;
    logic [7:0] lookup_index = '0;
    logic       touch_valid = 1'b0;
    logic [7:0] touch_index = '0;
    logic [2:0] touch_way = '0;
    logic       clear_start = 1'b0;

    logic       vv2, vv4, vv8;
    logic [0:0] vw2;
    logic [1:0] vw4;
    logic [2:0] vw8;
    logic       busy2, busy4, busy8;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int unsigned ts [NCFG][NSETS][8];
    int unsigned now_t;
    int          busy_left;
    bit          exp_vv [NCFG];
    int          exp_vw [NCFG];

    typedef struct {
        bit tv; int ti; int tw;
        bit lv; int li;
        int cfg; bit exp_v; int exp_w;
    } vec_t;
    vec_t vecs [10];

    // clock
    always #5 clk = ~clk;

    plru_state_array #(.NUM_SETS(NSETS), .WAYS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .lookup_valid(lookup_valid), .lookup_index(lookup_index),
        .victim_valid(vv2), .victim_way(vw2),
        .touch_valid(touch_valid), .touch_index(touch_index), .touch_way(touch_way[0:0]),
        .clear_start(clear_start), .busy(busy2)
    );
    plru_state_array #(.NUM_SETS(NSETS), .WAYS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .lookup_valid(lookup_valid), .lookup_index(lookup_index),
        .victim_valid(vv4), .victim_way(vw4),
        .touch_valid(touch_valid), .touch_index(touch_index), .touch_way(touch_way[1:0]),
        .clear_start(clear_start), .busy(busy4)
    );
    plru_state_array #(.NUM_SETS(NSETS), .WAYS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .lookup_valid(lookup_valid), .lookup_index(lookup_index),
        .victim_valid(vv8), .victim_way(vw8),
        .touch_valid(touch_valid), .touch_index(touch_index), .touch_way(touch_way),
        .clear_start(clear_start), .busy(busy8)
    );

    function automatic int dut_vv(input int c);
        case (c)
            0: return int'(vv2);
            1: return int'(vv4);
            default: return int'(vv8);
        endcase
    endfunction

    function automatic int dut_vw(input int c);
        case (c)
            0: return int'(vw2);
            1: return int'(vw4);
            default: return int'(vw8);
        endcase
    endfunction

    function automatic int dut_busy(input int c);
        case (c)
            0: return int'(busy2);
            1: return int'(busy4);
            default: return int'(busy8);
        endcase
    endfunction

    task automatic check_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int model_victim(input int c, input int s);
        int lo, size, half;
        int unsigned mlo, mhi;
        lo   = 0;
        size = WAYS_OF[c];
        while (size > 1) begin
            half = size / 2;
            mlo  = 0;
            mhi  = 0;
            for (int i = 0; i < half; i++) begin
                if (ts[c][s][lo + i] > mlo) mlo = ts[c][s][lo + i];
                if (ts[c][s][lo + half + i] > mhi) mhi = ts[c][s][lo + half + i];
            end
            if (mlo > mhi) lo = lo + half;
            size = half;
        end
        return lo;
    endfunction

    task automatic model_clear_all();
        for (int c = 0; c < NCFG; c++)
            for (int s = 0; s < NSETS; s++)
                for (int w = 0; w < 8; w++)
                    ts[c][s][w] = 0;
    endtask

    task automatic model_reset();
        model_clear_all();
        now_t     = 0;
        busy_left = 0;
        for (int c = 0; c < NCFG; c++) begin
            exp_vv[c] = 1'b0;
            exp_vw[c] = 0;
        end
    endtask

    task automatic model_step(input bit tv, input int ti, input int tw,
                              input bit lv, input int li, input bit cs);
        if (busy_left == 0) begin
            if (tv) begin
                now_t++;
                for (int c = 0; c < NCFG; c++) ts[c][ti][tw % WAYS_OF[c]] = now_t;
            end
            for (int c = 0; c < NCFG; c++) begin
                exp_vv[c] = lv;
                if (lv) exp_vw[c] = model_victim(c, li);
            end
            if (cs) begin
                model_clear_all();
                busy_left = NSETS;
            end
        end else begin
            for (int c = 0; c < NCFG; c++) exp_vv[c] = 1'b0;
            busy_left--;
        end
    endtask

    task automatic check_outputs();
        for (int c = 0; c < NCFG; c++) begin
            check_eq($sformatf("victim_valid_w%0d", WAYS_OF[c]), dut_vv(c), int'(exp_vv[c]));
            check_eq($sformatf("victim_way_w%0d", WAYS_OF[c]), dut_vw(c), exp_vw[c]);
            check_eq($sformatf("busy_w%0d", WAYS_OF[c]), dut_busy(c), (busy_left > 0) ? 1 : 0);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive one cycle of inputs, advance past the edge, compare to the model.
    task automatic cycle(input bit tv, input int ti, input int tw,
                         input bit lv, input int li, input bit cs);
        touch_valid  = tv;
        touch_index  = 8'(ti);
        touch_way    = 3'(tw);
        lookup_valid = lv;
        lookup_index = 8'(li);
        clear_start  = cs;
        model_step(tv, ti, tw, lv, li, cs);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Assert reset immediately (asynchronously), check, then release.
    task automatic apply_reset();
        rst_n        = 1'b0;
        touch_valid  = 1'b0;
        lookup_valid = 1'b0;
        clear_start  = 1'b0;
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;
        int idx;

        // tv ti tw lv li cfg exp_v exp_w   (cfg 0=2-way, 1=4-way)
        vecs[0] = '{1'b0, 0, 0, 1'b1, 5, 1, 1'b1, 0};
        vecs[1] = '{1'b0, 0, 0, 1'b0, 0, 1, 1'b0, 0};
        vecs[2] = '{1'b1, 5, 0, 1'b0, 0, 1, 1'b0, 0};
        vecs[3] = '{1'b0, 0, 0, 1'b1, 5, 1, 1'b1, 2};
        vecs[4] = '{1'b1, 5, 2, 1'b0, 0, 1, 1'b0, 2};
        vecs[5] = '{1'b0, 0, 0, 1'b1, 5, 1, 1'b1, 1};
        vecs[6] = '{1'b1, 5, 1, 1'b0, 0, 1, 1'b0, 1};
        vecs[7] = '{1'b0, 0, 0, 1'b1, 5, 1, 1'b1, 3};
        vecs[8] = '{1'b1, 7, 0, 1'b1, 7, 0, 1'b1, 1};
        vecs[9] = '{1'b1, 3, 0, 1'b1, 9, 0, 1'b1, 0};

        #2;
        apply_reset();

        // table: reset lookup, 4-way touch sequence, 2-way forwarding
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].tv, vecs[i].ti, vecs[i].tw, vecs[i].lv, vecs[i].li, 1'b0);
            check_eq($sformatf("tbl%0d_valid", i), dut_vv(vecs[i].cfg), int'(vecs[i].exp_v));
            check_eq($sformatf("tbl%0d_way", i), dut_vw(vecs[i].cfg), vecs[i].exp_w);
        end

        // random touch/lookup pairs against the model
        for (int i = 0; i < 2000; i++) begin
            cycle(1'b1, $urandom_range(0, 15), $urandom_range(0, 7),
                  1'b1, $urandom_range(0, 15), 1'b0);
        end

        // clear sequence with traffic and clear_start re-pulses during busy
        cycle(1'b1, 0, 3, 1'b0, 0, 1'b0);
        cycle(1'b1, 128, 5, 1'b0, 0, 1'b0);
        cycle(1'b1, 255, 7, 1'b1, 255, 1'b0);
        cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
        busy_cnt = int'(busy8);
        for (int i = 0; i < 299; i++) begin
            if (busy_left > 0) begin
                case ($urandom_range(0, 2))
                    0: idx = 0;
                    1: idx = 128;
                    default: idx = 255;
                endcase
                cycle(1'($urandom_range(0, 1)), idx, $urandom_range(0, 7),
                      1'($urandom_range(0, 1)), idx, 1'($urandom_range(0, 1)));
            end else begin
                cycle(1'b0, 0, 0, 1'b0, 0, 1'b0);
            end
            busy_cnt += int'(busy8);
        end
        check_eq("clear_busy_cycles", busy_cnt, 256);
        cycle(1'b0, 0, 0, 1'b1, 0, 1'b0);
        check_eq("post_clear_set0", dut_vw(2), 0);
        cycle(1'b0, 0, 0, 1'b1, 128, 1'b0);
        check_eq("post_clear_set128", dut_vw(2), 0);
        cycle(1'b0, 0, 0, 1'b1, 255, 1'b0);
        check_eq("post_clear_set255", dut_vw(2), 0);

        // reset in the middle of a sweep
        for (int i = 0; i < 64; i++) begin
            cycle(1'b1, $urandom_range(0, 255), $urandom_range(0, 7), 1'b0, 0, 1'b0);
        end
        cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
        for (int i = 1; i < 40; i++) cycle(1'b0, 0, 0, 1'b0, 0, 1'b0);
        check_eq("busy_before_rst", int'(busy8), 1);
        apply_reset();
        check_eq("busy_after_rst", int'(busy8), 0);
        for (int s = 0; s < NSETS; s++) begin
            cycle(1'b0, 0, 0, 1'b1, s, 1'b0);
            check_eq($sformatf("post_rst_set%0d", s), dut_vw(2), 0);
        end
        cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
        check_eq("clear_after_rst", int'(busy8), 1);
        busy_cnt = 1;
        for (int i = 0; i < 299; i++) begin
            cycle(1'b0, 0, 0, 1'b0, 0, 1'b0);
            busy_cnt += int'(busy8);
        end
        check_eq("clear_after_rst_cycles", busy_cnt, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/plru_state_array.md
Name: plru_state_array

Overview:
- Per-set replacement-state store for the set-associative data/instruction caches. It generalises the 2-way single-bit LRU select into a tree pseudo-LRU over a parametrised set count and associativity.
- Holds WAYS-1 PLRU bits per set, returns a registered victim way per lookup, and updates state on touch (hit/fill).
- Provides a sequenced whole-array clear for cache flush.
- Sits beside the tag array, driven by the cache controller FSM.

Parameters:
- NUM_SETS, 256, number of sets; power of 2, >= 2.
- WAYS, 2, associativity; power of 2 in {2, 4, 8}.
- INDEX_W, $clog2(NUM_SETS), set index width; derived, do not override.
- WAY_W, $clog2(WAYS), way number width; derived.

Ports:
- clk  in  1  Clock; all state changes on the rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- lookup_valid  in  1  Request the victim for lookup_index.
- lookup_index  in  INDEX_W  Set being looked up.
- victim_valid  out  1  victim_way holds a result; registered.
- victim_way  out  WAY_W  Way to replace; registered.
- touch_valid  in  1  Mark touch_way as most recently used in touch_index.
- touch_index  in  INDEX_W  Set being touched.
- touch_way  in  WAY_W  Way accessed (hit or fill).
- clear_start  in  1  Pulse; start a sequenced clear of all sets.
- busy  out  1  Clear sequence in progress.

Behaviour:
- Storage: NUM_SETS x (WAYS-1) bits, heap-ordered per set. Node n (root n=1, children 2n and 2n+1) is stored in bit n-1. Bit value 0 means the victim lies in the lower-numbered subtree; 1 means the higher-numbered subtree.
- Victim walk: start at n=1; repeat WAY_W times: n = 2n + bit[n-1]. Result way = n - WAYS.
- Touch update: on every node along the path to touch_way, set the bit to point away from touch_way. For WAYS=2 this reduces to bit = ~touch_way.
- Async reset (rst_n=0):
  - All PLRU bits = 0; FSM = IDLE.
  - victim_valid=0, victim_way=0, busy=0.
  - Takes effect immediately and aborts any clear in progress.
- Lookup latency: 1 cycle.
  - lookup_valid in cycle N gives victim_valid=1 and victim_way in cycle N+1.
  - With no lookup, victim_valid=0 and victim_way holds its last value.
- Touch: state is written at the end of the cycle in which touch_valid=1.
- Simultaneous lookup and touch to the same index in the same cycle: the victim is computed from the post-touch state (write-forwarding).
- Simultaneous lookup and touch to different indices: independent; the victim uses the current state.
- FSM states:
  - IDLE --clear_start--> CLEAR (clear_ptr = 0, busy = 1 from the next cycle).
  - CLEAR: each cycle writes set clear_ptr to 0 and increments clear_ptr. When clear_ptr = NUM_SETS-1 is written, go to IDLE; busy = 0 on the following cycle.
  - A full clear takes exactly NUM_SETS cycles of busy=1.
- While busy=1:
  - lookup_valid and touch_valid are ignored; victim_valid=0.
  - clear_start is ignored; the sweep does not restart.
- clear_start in IDLE in the same cycle as a touch: the touch is performed, then overwritten by the clear.
- The index counter wraps only via the explicit terminate; it never runs past NUM_SETS-1.

Test Plan:
- Reset, WAYS=4: release rst_n, lookup set 5 -> victim_valid=1 next cycle, victim_way=0. Idle cycle -> victim_valid=0.
- WAYS=4 set 5: touch way 0 -> lookup gives way 2. Touch way 2 -> lookup gives way 1. Touch way 1 -> lookup gives way 3.
- Forwarding, WAYS=2: lookup set 7 and touch set 7 way 0 in the same cycle -> victim_way=1. Touch set 3 way 0 while looking up set 9 -> set 9 victim_way=0.
- Clear, NUM_SETS=256: touch sets 0, 128, 255, then pulse clear_start.
  - busy=1 for exactly 256 cycles.
  - Lookups and touches issued during busy give no victim_valid and do not alter state.
  - Afterwards, lookups of sets 0, 128 and 255 return way 0.
- Reset mid-clear: assert rst_n=0 at cycle 40 of the sweep -> busy=0 immediately. After release, every set's victim is 0, and a new clear_start is accepted.
- Sweep WAYS=8 against a reference model: 2000 random touch/lookup pairs must match the model's victim every cycle.
